// File: rtl/sw_array_driver.sv
// Host-side driver for a linear Smith-Waterman PE array.
// Loads a NUM_PE-base query into the array, streams reference bases into PE0,
// and tracks the best score seen at the last PE. The result is returned with
// its 1-based reference position on a valid/ready port.
module sw_array_driver #(
  parameter int NUM_PE = 16,
  parameter int WIDTH  = 10,
  parameter int POS_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic [1:0]              q_base,
  input  logic                    ref_valid,
  output logic                    ref_ready,
  input  logic [1:0]              ref_base,
  input  logic                    ref_last,
  output logic [1:0]              arr_S,
  output logic                    arr_store_S,
  output logic [1:0]              arr_T,
  output logic                    arr_init,
  output logic [WIDTH-1:0]        arr_V,
  output logic [WIDTH-1:0]        arr_F,
  input  logic signed [WIDTH-1:0] last_V,
  input  logic                    last_init,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_score,
  output logic [POS_W-1:0]        res_pos,
  output logic                    res_err
);

  // Query index needs to reach NUM_PE (end of the shift phase).
  localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int SW = $clog2(NUM_PE + 1);
  localparam int DW = $clog2(NUM_PE + 3);
  // An accept at this count brings ref_cnt to its maximum; no further accept fits.
  localparam logic [POS_W-1:0] CNT_LAST = {{(POS_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Q,
    SHIFT_Q,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  logic [1:0]              qbuf [NUM_PE];
  logic [SW-1:0]           qidx;
  logic                    started;
  logic                    err;
  logic [POS_W-1:0]        ref_cnt;
  logic [DW-1:0]           drain_cnt;
  logic [POS_W-1:0]        col_cnt;
  logic [POS_W-1:0]        bpos;
  logic signed [WIDTH-1:0] best;
  logic                    seen_init;

  logic q_acc;
  logic ref_acc;
  logic res_acc;
  logic col_active;
  logic drain_exit;

  assign q_acc      = q_valid & q_ready;
  assign ref_acc    = ref_valid & ref_ready;
  assign res_acc    = res_valid & res_ready;
  assign col_active = (state == STREAM) || (state == DRAIN);
  // Leave on the falling edge of last_init, or on timeout if it never rose.
  assign drain_exit = (seen_init && !last_init) ||
                      (!seen_init && !last_init && (drain_cnt == DW'(NUM_PE + 1)));

  // The array's boundary column is always zero.
  assign arr_V = '0;
  assign arr_F = '0;

  // Control FSM: query load, shift into the array, reference stream, drain, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_ready     <= 1'b0;
      ref_ready   <= 1'b0;
      arr_S       <= 2'd0;
      arr_store_S <= 1'b0;
      arr_T       <= 2'd0;
      arr_init    <= 1'b0;
      res_valid   <= 1'b0;
      res_score   <= '0;
      res_pos     <= '0;
      res_err     <= 1'b0;
      qidx        <= '0;
      started     <= 1'b0;
      err         <= 1'b0;
      ref_cnt     <= '0;
      drain_cnt   <= '0;
      for (int i = 0; i < NUM_PE; i++) qbuf[i] <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          q_ready <= 1'b1;
          if (q_acc) begin
            qbuf[0] <= q_base;
            qidx    <= SW'(1);
            state   <= LOAD_Q;
          end
        end
        LOAD_Q: begin
          if (q_acc) begin
            qbuf[qidx[IW-1:0]] <= q_base;
            if (qidx == SW'(NUM_PE - 1)) begin
              // First shift cycle is presented directly on the transition.
              q_ready     <= 1'b0;
              arr_S       <= qbuf[0];
              arr_store_S <= 1'b1;
              qidx        <= SW'(1);
              state       <= SHIFT_Q;
            end else begin
              qidx <= qidx + 1'b1;
            end
          end
        end
        SHIFT_Q: begin
          arr_store_S <= 1'b0;
          if (qidx == SW'(NUM_PE)) begin
            arr_S     <= 2'd0;
            ref_ready <= 1'b1;
            qidx      <= '0;
            state     <= STREAM;
          end else begin
            arr_S <= qbuf[qidx[IW-1:0]];
            qidx  <= qidx + 1'b1;
          end
        end
        STREAM: begin
          if (ref_acc) begin
            arr_T    <= ref_base;
            arr_init <= 1'b1;
            started  <= 1'b1;
            ref_cnt  <= ref_cnt + 1'b1;
            if (ref_last) begin
              ref_ready <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else if (ref_cnt == CNT_LAST) begin
              // Counter is full: the next cycle cannot accept and becomes a bubble.
              ref_ready <= 1'b0;
            end
          end else begin
            arr_init <= 1'b0;
            arr_T    <= 2'd0;
            if (started) begin
              // The array cannot stall, so a gap mid-stream aborts the run.
              err       <= 1'b1;
              ref_ready <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          arr_init  <= 1'b0;
          arr_T     <= 2'd0;
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_exit) begin
            res_valid <= 1'b1;
            res_score <= err ? '0 : best;
            res_pos   <= err ? '0 : bpos;
            res_err   <= err;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_acc) begin
            res_valid <= 1'b0;
            res_score <= '0;
            res_pos   <= '0;
            res_err   <= 1'b0;
            err       <= 1'b0;
            started   <= 1'b0;
            ref_cnt   <= '0;
            drain_cnt <= '0;
            qidx      <= '0;
            for (int i = 0; i < NUM_PE; i++) qbuf[i] <= 2'd0;
            q_ready   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Collector: running signed maximum of the last PE's score and where it occurred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      bpos      <= '0;
      best      <= '0;
      seen_init <= 1'b0;
    end else if ((state == DONE) && res_acc) begin
      col_cnt   <= '0;
      bpos      <= '0;
      best      <= '0;
      seen_init <= 1'b0;
    end else if (col_active && last_init) begin
      col_cnt   <= col_cnt + 1'b1;
      seen_init <= 1'b1;
      // Strict compare keeps the earliest position on ties.
      if (last_V > best) begin
        best <= last_V;
        bpos <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sw_array_driver.sv
// Directed bench for sw_array_driver with a small PE-array stand-in:
// init is delayed NUM_PE cycles to the last PE and last_V is played from a table.
module tb_sw_array_driver;

  localparam int NUM_PE = 4;
  localparam int WIDTH  = 10;
  localparam int POS_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    q_valid = 1'b0;
  logic                    q_ready;
  logic [1:0]              q_base = 2'd0;
  logic                    ref_valid = 1'b0;
  logic                    ref_ready;
  logic [1:0]              ref_base = 2'd0;
  logic                    ref_last = 1'b0;
  logic [1:0]              arr_S;
  logic                    arr_store_S;
  logic [1:0]              arr_T;
  logic                    arr_init;
  logic [WIDTH-1:0]        arr_V;
  logic [WIDTH-1:0]        arr_F;
  logic signed [WIDTH-1:0] last_V;
  logic                    last_init;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic signed [WIDTH-1:0] res_score;
  logic [POS_W-1:0]        res_pos;
  logic                    res_err;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  sw_array_driver #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .q_valid(q_valid), .q_ready(q_ready), .q_base(q_base),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_base(ref_base), .ref_last(ref_last),
    .arr_S(arr_S), .arr_store_S(arr_store_S), .arr_T(arr_T), .arr_init(arr_init),
    .arr_V(arr_V), .arr_F(arr_F),
    .last_V(last_V), .last_init(last_init),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_pos(res_pos), .res_err(res_err)
  );

  // PE array stand-in
  logic [NUM_PE-1:0]       dl;
  logic [NUM_PE-1:0]       stc;
  logic [1:0]              pe_q [NUM_PE];
  logic [2:0]              colx;
  logic signed [WIDTH-1:0] vtab [8];

  assign last_init = dl[NUM_PE-1];
  assign last_V    = last_init ? vtab[colx] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl   <= '0;
      stc  <= '0;
      colx <= '0;
    end else begin
      dl  <= {dl[NUM_PE-2:0], arr_init};
      stc <= {stc[NUM_PE-2:0], arr_store_S};
      if (res_valid && res_ready) colx <= '0;
      else if (last_init)         colx <= colx + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (arr_store_S) pe_q[0] <= arr_S;
    for (int k = 1; k < NUM_PE; k++)
      if (stc[k-1]) pe_q[k] <= arr_S;
  end

  // Cycle stamps for the latency check (signals sampled at the edge ending each cycle).
  int   cyc = 0;
  int   acc_cyc = -1;
  int   rv_cyc = -1;
  logic rv_prev = 1'b0;
  always @(posedge clk) begin
    if (ref_valid && ref_ready && ref_last) acc_cyc = cyc;
    if (res_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = res_valid;
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_q(input logic [1:0] b);
    bit done = 0;
    q_valid = 1'b1;
    q_base  = b;
    for (int n = 0; n < 50 && !done; n++) begin
      if (q_ready) done = 1;
      tick();
    end
    q_valid = 1'b0;
    if (!done) check("q_accept_timeout", 0, 1);
  endtask

  task automatic send_ref(input logic [1:0] b, input logic last);
    bit done = 0;
    ref_valid = 1'b1;
    ref_base  = b;
    ref_last  = last;
    for (int n = 0; n < 50 && !done; n++) begin
      if (ref_ready) done = 1;
      tick();
    end
    if (!done) check("ref_accept_timeout", 0, 1);
  endtask

  task automatic load_query(input logic [1:0] b0, input logic [1:0] b1,
                            input logic [1:0] b2, input logic [1:0] b3);
    send_q(b0); tick();
    send_q(b1); tick();
    send_q(b2);
    send_q(b3);
  endtask

  task automatic run_ref(input logic [1:0] b0, input logic [1:0] b1,
                         input logic [1:0] b2, input logic [1:0] b3);
    send_ref(b0, 1'b0);
    send_ref(b1, 1'b0);
    send_ref(b2, 1'b0);
    send_ref(b3, 1'b1);
    ref_valid = 1'b0;
    ref_last  = 1'b0;
  endtask

  task automatic wait_res();
    bit done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (res_valid) done = 1;
      else tick();
    end
    if (!done) check("res_valid_timeout", 0, 1);
  endtask

  task automatic set_vtab(input int v0, input int v1, input int v2, input int v3);
    vtab[0] = WIDTH'(v0); vtab[1] = WIDTH'(v1);
    vtab[2] = WIDTH'(v2); vtab[3] = WIDTH'(v3);
    for (int i = 4; i < 8; i++) vtab[i] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vtab(0, 0, 0, 0);
    // Reset state
    tick(); tick();
    check("rst_q_ready", q_ready, 0);
    check("rst_ref_ready", ref_ready, 0);
    check("rst_arr_init", arr_init, 0);
    check("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_q_ready", q_ready, 1);

    // Query load with bubbles and the shift phase
    load_query(2'd0, 2'd1, 2'd2, 2'd3);
    check("load_q_ready_drop", q_ready, 0);
    for (int c = 0; c < NUM_PE; c++) begin
      check($sformatf("shift_S_%0d", c), arr_S, c);
      check($sformatf("shift_store_%0d", c), arr_store_S, (c == 0) ? 1 : 0);
      tick();
    end
    check("stream_ref_ready", ref_ready, 1);
    for (int k = 0; k < NUM_PE; k++) check($sformatf("pe_q_%0d", k), pe_q[k], k);

    // ACGT vs ACGT: last PE column scores 0,2,5,8
    set_vtab(0, 2, 5, 8);
    send_ref(2'd0, 1'b0);
    send_ref(2'd1, 1'b0);
    send_ref(2'd2, 1'b0);
    send_ref(2'd3, 1'b1);
    ref_valid = 1'b0; ref_last = 1'b0;
    check("last_drive_init", arr_init, 1);
    check("last_drive_T", arr_T, 3);
    check("ref_ready_after_last", ref_ready, 0);
    wait_res();
    check("match_score", res_score, 8);
    check("match_pos", res_pos, 4);
    check("match_err", res_err, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("match_latency", rv_cyc - acc_cyc, NUM_PE + 3);
    check("match_idle_q_ready", q_ready, 1);
    check("match_res_cleared", res_valid, 0);

    // AAAA vs CCCC: no positive score anywhere
    set_vtab(0, 0, 0, 0);
    load_query(2'd0, 2'd0, 2'd0, 2'd0);
    run_ref(2'd1, 2'd1, 2'd1, 2'd1);
    wait_res();
    check("nomatch_score", res_score, 0);
    check("nomatch_pos", res_pos, 0);
    check("nomatch_err", res_err, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Bubble after two accepts aborts the stream
    set_vtab(3, 5, 0, 0);
    load_query(2'd0, 2'd1, 2'd2, 2'd3);
    send_ref(2'd0, 1'b0);
    send_ref(2'd1, 1'b0);
    check("bubble_pre_init", arr_init, 1);
    ref_valid = 1'b0;
    tick();
    check("bubble_init_drop", arr_init, 0);
    check("bubble_ref_ready", ref_ready, 0);
    wait_res();
    check("bubble_err", res_err, 1);
    check("bubble_score", res_score, 0);
    check("bubble_pos", res_pos, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Negative scores and a tie: earliest position of the signed maximum wins; hold result
    set_vtab(-3, 4, 4, 2);
    load_query(2'd3, 2'd2, 2'd1, 2'd0);
    run_ref(2'd0, 2'd1, 2'd2, 2'd3);
    wait_res();
    for (int n = 0; n < 10; n++) begin
      check($sformatf("hold_valid_%0d", n), res_valid, 1);
      check($sformatf("hold_score_%0d", n), res_score, 4);
      check($sformatf("hold_pos_%0d", n), res_pos, 2);
      tick();
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("hold_release_valid", res_valid, 0);
    check("hold_release_q_ready", q_ready, 1);

    // Asynchronous reset in the middle of a stream
    set_vtab(0, 2, 5, 8);
    load_query(2'd0, 2'd1, 2'd2, 2'd3);
    send_ref(2'd0, 1'b0);
    send_ref(2'd1, 1'b0);
    ref_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ref_ready", ref_ready, 0);
    check("arst_arr_init", arr_init, 0);
    check("arst_arr_T", arr_T, 0);
    check("arst_q_ready", q_ready, 0);
    check("arst_res_valid", res_valid, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    set_vtab(0, 2, 5, 8);
    load_query(2'd0, 2'd1, 2'd2, 2'd3);
    run_ref(2'd0, 2'd1, 2'd2, 2'd3);
    wait_res();
    check("post_rst_score", res_score, 8);
    check("post_rst_pos", res_pos, 4);
    check("post_rst_err", res_err, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sw_array_driver.md
Name: sw_array_driver

Overview:
- Host-side front end and back end for a linear Smith-Waterman PE array.
- Buffers a NUM_PE-base query and loads it into the array via the store_S shift chain and the broadcast S bus.
- Streams reference bases into PE0 with init asserted.
- Watches the last PE's V/init outputs and returns the best local-alignment score and its reference position through a valid/ready result port.

Parameters:
NUM_PE, 16, number of PEs in the array; query length is exactly NUM_PE (host pads).
WIDTH, 10, score width; matches the PE array score width.
POS_W, 16, width of the reference position counter and result position.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
q_valid  input  1  query base valid
q_ready  output  1  query base accepted when q_valid&q_ready
q_base  input  2  query base
ref_valid  input  1  reference base valid
ref_ready  output  1  reference base accepted when ref_valid&ref_ready
ref_base  input  2  reference base
ref_last  input  1  marks final reference base
arr_S  output  2  broadcast query bus to all PEs' S_in
arr_store_S  output  1  store pulse into PE0 store_S_in
arr_T  output  2  reference base into PE0 T_in
arr_init  output  1  computation active into PE0 init_in
arr_V  output  WIDTH  boundary score into PE0 V_in, constant 0
arr_F  output  WIDTH  boundary gap into PE0 F_in, constant 0
last_V  input  WIDTH  V_out of PE NUM_PE-1, signed
last_init  input  1  init_out of PE NUM_PE-1
res_valid  output  1  result valid
res_ready  input  1  result consumed when res_valid&res_ready
res_score  output  WIDTH  best score, signed
res_pos  output  POS_W  1-based reference index of best score
res_err  output  1  stream aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (q_ready, ref_ready, arr_*, res_*). Query buffer, counters, best score and best position cleared. Reset mid-operation aborts with no result.
- All array-side outputs are registered.
- IDLE:
  - q_ready=1.
  - First accepted q_base is written to qbuf[0]; go to LOAD_Q.
- LOAD_Q:
  - q_ready=1. Bubbles allowed.
  - Accepted bases fill qbuf[1..NUM_PE-1] in order.
  - After the NUM_PE-th accept, q_ready=0 next cycle; go to SHIFT_Q.
- SHIFT_Q (exactly NUM_PE cycles, c=0..NUM_PE-1):
  - arr_S=qbuf[c] in cycle c.
  - arr_store_S=1 only in cycle c=0.
  - As a result, PE k latches qbuf[k]. Then go to STREAM.
- STREAM:
  - ref_ready=1.
  - A base accepted in cycle a is driven as arr_T=base, arr_init=1 in cycle a+1.
  - ref_cnt increments per accept.
  - Accept with ref_last=1: ref_ready=0 from the next cycle; go to DRAIN.
  - Bubble (ref_valid=0 in STREAM after ≥1 accept): arr_init=0 next cycle, err flag set, go to DRAIN. The array cannot stall.
  - ref_cnt would exceed 2^POS_W-1: treated as a bubble (error).
  - No accept yet: waiting is allowed, not an error.
- Collector (active in STREAM and DRAIN):
  - Each cycle with last_init=1: col_cnt increments.
  - If signed last_V > best, then best<=last_V and bpos<=col_cnt+1.
  - Strict > means the earliest position wins ties. best initialises to 0, bpos to 0.
- DRAIN:
  - arr_init=0.
  - Exit on the falling edge of last_init, or NUM_PE+2 cycles after the last drive if last_init never rose.
  - Then go to DONE.
- DONE:
  - res_valid=1; res_score=best; res_pos=bpos; res_err=err.
  - On an error, score/pos are forced to 0.
  - Outputs held stable until res_valid&res_ready, then go to IDLE with all state cleared.
- Latency: the last base accepted at cycle a reaches the last PE's init_out at a+1+NUM_PE. res_valid rises at a+3+NUM_PE.
- Width: scores are compared as signed WIDTH; no arithmetic on scores in this block.

Test Plan:
1. NUM_PE=4, query ACGT (0,1,2,3) with q_valid bubbles -> in SHIFT_Q, arr_S=0,1,2,3 on consecutive cycles; arr_store_S high only the first cycle; PE k holds query[k].
2. Query ACGT, ref ACGT contiguous with ref_last on the 4th base (array scoring +2/-2/-2/-1) -> res_score=8, res_pos=4, res_err=0; res_valid rises exactly NUM_PE+3 cycles after the ref_last accept.
3. Query AAAA, ref CCCC -> res_score=0, res_pos=0, res_err=0.
4. Ref bubble after 2 accepts -> arr_init drops next cycle; res_valid with res_err=1, res_score=0, res_pos=0; ref_ready=0 after the bubble.
5. res_ready held low 10 cycles -> res_* stable throughout; one accept returns to IDLE with q_ready=1.
6. rst_n asserted mid-STREAM -> all outputs 0 immediately (async); after release, a fresh query+ref run gives the correct result.
